// File: rtl/mpei_apb_arb_pkg.sv
// mpei_apb_arb_pkg: shared types and default widths for the two-master APB arbiter
package mpei_apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  typedef logic gidx_t;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TO_W_DEF = 8;
  localparam int TO_CYC_DEF = 255;
endpackage

// File: rtl/mpei_rr_arb2.sv
// mpei_rr_arb2: two-requester round-robin picker, the master that did not win last time wins a tie
module mpei_rr_arb2
  import mpei_apb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  gidx_t lst;
  always_comb begin
    lst = last;
    gnt = (&req) ? (lst ? 2'b01 : 2'b10) : req;
  end
endmodule

// File: rtl/mpei_apb_arb.sv
// mpei_apb_arb: two-master APB3 arbiter, round-robin grant with a registered SETUP/ACCESS relaunch
// Optional ACCESS timeout enabled by defining MPEI_APB_ARB_TIMEOUT_EN.
module mpei_apb_arb
  import mpei_apb_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TO_W   = TO_W_DEF,
  parameter int TO_CYC = TO_CYC_DEF
)(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic              m0_pwrite,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic              m1_pwrite,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic              s_psel,
  output logic              s_penable,
  output logic [ADDR_W-1:0] s_paddr,
  output logic              s_pwrite,
  output logic [DATA_W-1:0] s_pwdata,
  input  logic [DATA_W-1:0] s_prdata,
  input  logic              s_pready,
  input  logic              s_pslverr,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);
  state_t     state;
  gidx_t      rr_last;
  logic [1:0] gnt;
  logic       done, to_hit;
  logic       unused_pen;
  assign unused_pen = ^{m0_penable, m1_penable};
  mpei_rr_arb2 u_rr (.req({m1_psel, m0_psel}), .last(rr_last), .gnt(gnt));
`ifdef MPEI_APB_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  assign to_hit = (state == ACCESS) && !s_pready && (to_cnt == TO_W'(TO_CYC));
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) to_cnt <= '0;
    else if (state == SETUP) to_cnt <= '0;
    else if (state == ACCESS && !s_pready && !to_hit) to_cnt <= to_cnt + 1'b1;
`else
  localparam int unused_to = TO_W + TO_CYC;
  assign to_hit = 1'b0;
`endif
  assign done       = (state == ACCESS) && (s_pready || to_hit);
  assign timeout_o  = to_hit;
  assign m0_pready  = done && grant_o[0];
  assign m1_pready  = done && grant_o[1];
  assign m0_pslverr = m0_pready && (s_pslverr || to_hit);
  assign m1_pslverr = m1_pready && (s_pslverr || to_hit);
  assign m0_prdata  = (m0_pready && !to_hit) ? s_prdata : '0;
  assign m1_prdata  = (m1_pready && !to_hit) ? s_prdata : '0;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      grant_o   <= '0;
      s_psel    <= 1'b0;
      s_penable <= 1'b0;
      s_paddr   <= '0;
      s_pwrite  <= 1'b0;
      s_pwdata  <= '0;
    end else begin
      case (state)
        IDLE:
          if (|gnt) begin
            state    <= SETUP;
            grant_o  <= gnt;
            rr_last  <= gnt[1];
            s_psel   <= 1'b1;
            s_paddr  <= gnt[1] ? m1_paddr  : m0_paddr;
            s_pwrite <= gnt[1] ? m1_pwrite : m0_pwrite;
            s_pwdata <= gnt[1] ? m1_pwdata : m0_pwdata;
          end
        SETUP: begin
          state     <= ACCESS;
          s_penable <= 1'b1;
        end
        ACCESS:
          if (done) begin
            state     <= IDLE;
            grant_o   <= '0;
            s_psel    <= 1'b0;
            s_penable <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mpei_apb_arb.md
Name: mpei_apb_arb

Overview:
Two-master APB3 arbiter that shares the MCU peripheral APB bus (spictrl, apbuart, gpio, grtimer) between the SCR1 AHB-to-APB bridge (master 0) and a second master such as a DMA or debug engine (master 1). It performs round-robin grant and re-launches the granted transfer on the slave side through a registered SETUP/ACCESS sequence. Each master's PREADY is held low until its own transfer completes.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TO_W, 8, timeout counter width (used only with the optional feature)
TO_CYC, 255, ACCESS cycles without s_pready before forced termination; must be ≤ 2^TO_W-1

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
m0_psel, m1_psel  in  1  master request (APB setup/access select)
m0_penable, m1_penable  in  1  master access phase
m0_paddr, m1_paddr  in  ADDR_W  address
m0_pwrite, m1_pwrite  in  1  1 = write
m0_pwdata, m1_pwdata  in  DATA_W  write data
m0_prdata, m1_prdata  out  DATA_W  read data, valid when the matching pready=1
m0_pready, m1_pready  out  1  transfer complete
m0_pslverr, m1_pslverr  out  1  error, valid with pready
s_psel  out  1  slave-side select
s_penable  out  1  slave-side enable
s_paddr  out  ADDR_W  latched address
s_pwrite  out  1  latched direction
s_pwdata  out  DATA_W  latched write data
s_prdata  in  DATA_W  slave read data
s_pready  in  1  slave ready
s_pslverr  in  1  slave error
grant_o  out  2  one-hot owner; 00 when idle
timeout_o  out  1  one-cycle pulse on forced termination (0 when feature is off)

Behaviour:
- Clock and reset: single clock clk_i; rstn_i is asynchronous assert, active-low.
- Reset values: state=IDLE; rr_last=1, so m0 wins the first tie; all outputs 0.
- FSM IDLE:
  - Requests are sampled when mN_psel=1.
  - One request: grant that master.
  - Both requesting: grant the master ≠ rr_last.
  - On grant: latch paddr/pwrite/pwdata into s_* registers, set grant_o and rr_last, go to SETUP.
- FSM SETUP: s_psel=1, s_penable=0; go to ACCESS unconditionally.
- FSM ACCESS: s_psel=1, s_penable=1.
  - When s_pready=1 (combinational): granted mN_pready=1, mN_prdata=s_prdata, mN_pslverr=s_pslverr.
  - Next state IDLE. s_psel, s_penable and grant_o clear on the next edge.
- Non-granted master: pready=0, prdata=0, pslverr=0. It waits, holding its request.
- Latency:
  - Request seen in IDLE at cycle T gives s_psel at T+1 and s_penable at T+2.
  - Zero-wait slave gives mN_pready at T+2.
  - Minimum 3 cycles per transfer including the IDLE cycle; the bus is never idle for more than 1 cycle between queued transfers.
- Fairness:
  - Both masters requesting continuously: grants alternate m0, m1, m0, …
  - A sole requester is granted every transfer.
- The latched s_* registers are stable from SETUP through ACCESS, independent of master inputs.
- If the granted master drops psel mid-transfer (protocol violation), the slave transfer still completes; the pready pulse is driven regardless.
- A master's psel is not re-sampled until IDLE, so a master already holding pready=1 cannot double-issue.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. The slave sees psel drop asynchronously.

Optional Feature:
- Macro MPEI_APB_ARB_TIMEOUT_EN.
- Defined:
  - to_cnt counts ACCESS cycles with s_pready=0.
  - When to_cnt reaches TO_CYC and s_pready is still 0: granted mN_pready=1, mN_pslverr=1, mN_prdata=0, timeout_o=1 for that cycle, next state IDLE.
  - to_cnt clears on entry to SETUP.
  - s_pready=1 in the same cycle as the limit: the normal completion wins and there is no timeout.
- Undefined: no counter; ACCESS waits indefinitely; timeout_o tied to 0.

Decomposition:
- Package mpei_apb_arb_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - grant index type
  - default widths
- Sub-module mpei_rr_arb2: 2-requester round-robin picker. Inputs req[1:0] and last; outputs one-hot gnt. Combinational.
- FSM, latches and timeout counter live in the top.

Test Plan:
- Reset: hold rstn_i=0 with both psel=1 → all outputs 0; after release, m0 granted first (grant_o=01 at T+1).
- Single write: m0 writes 0x8000_0004 / 0xDEAD_BEEF, zero-wait slave → s_psel at T+1, s_penable at T+2, m0_pready=1 at T+2; m1_pready stays 0.
- Contention: both masters request continuously for 6 transfers → grant order m0, m1, m0, m1, m0, m1; each read returns the correct s_prdata (0x11, 0x22, …) to the correct master.
- Wait states and error: slave holds s_pready=0 for 5 ACCESS cycles, then s_pready=1 with s_pslverr=1 → s_paddr and s_pwdata stable throughout; m1_pready=1 and m1_pslverr=1 in exactly that cycle.
- Timeout (MPEI_APB_ARB_TIMEOUT_EN, TO_CYC=4): slave never ready → after 4 ACCESS cycles, mN_pslverr=1, prdata=0, timeout_o pulses once; FSM returns to IDLE and the next request is served normally.
- Reset mid-ACCESS: assert rstn_i while in ACCESS → s_psel=0 immediately; after release, no spurious pready on either master.
